// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: streams the 16 round subkeys over valid/ready,
// K1..K16 for encryption or K16..K1 for decryption, one subkey per transfer.
module des_key_sched_seq #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_idx,
  output logic        subkey_last,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        parity_err
);

  typedef enum logic {IDLE, GEN} state_e;

  // Permuted choice 1: DES key bit numbers (1 = MSB) feeding C (first 28) then D.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: C||D bit numbers (1 = MSB of C) forming the subkey.
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit r set where round r+1 shifts by one position (rounds 1, 2, 9, 16).
  localparam logic [15:0] SH1_MASK = 16'h8103;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Odd parity per byte is the DES convention; any even byte is flagged.
  function automatic logic even_byte_any(input logic [63:0] k);
    logic r;
    r = 1'b0;
    for (int b = 0; b < 8; b++) r = r | ~(^k[8*b +: 8]);
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  count_q, count_d;
  logic        mode_q, mode_d;
  logic        key_ready_q, key_ready_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;

  logic [55:0] key_pc1;
  logic [27:0] c_ld, d_ld, c_nx, d_nx;
  logic [3:0]  count_nx, sh_idx;
  logic        sh_two;

  // Next-state, next C/D and next presented subkey.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    d_d         = d_q;
    count_d     = count_q;
    mode_d      = mode_q;
    key_ready_d = key_ready_q;
    subkey_d    = subkey_q;
    idx_d       = idx_q;
    last_d      = last_q;
    valid_d     = valid_q;
    perr_d      = perr_q;

    // Load: encrypt presents C1/D1 (one left shift); decrypt presents C16/D16 = C0/D0.
    key_pc1 = pc1(key_in);
    c_ld    = decrypt ? key_pc1[55:28] : rotl28(key_pc1[55:28], 1'b0);
    d_ld    = decrypt ? key_pc1[27:0]  : rotl28(key_pc1[27:0],  1'b0);

    // Advance: encrypt shifts left by SH of the next round; decrypt undoes the current round.
    count_nx = count_q + 4'd1;
    sh_idx   = mode_q ? (4'd15 - count_q) : count_nx;
    sh_two   = ~SH1_MASK[sh_idx];
    c_nx     = mode_q ? rotr28(c_q, sh_two) : rotl28(c_q, sh_two);
    d_nx     = mode_q ? rotr28(d_q, sh_two) : rotl28(d_q, sh_two);

    case (state_q)
      IDLE: begin
        if (key_load && key_ready_q) begin
          state_d     = GEN;
          c_d         = c_ld;
          d_d         = d_ld;
          count_d     = 4'd0;
          mode_d      = decrypt;
          key_ready_d = 1'b0;
          subkey_d    = pc2({c_ld, d_ld});
          idx_d       = decrypt ? 4'd15 : 4'd0;
          last_d      = 1'b0;
          valid_d     = 1'b1;
          perr_d      = CHECK_PARITY & even_byte_any(key_in);
        end
      end
      GEN: begin
        if (subkey_ready) begin
          if (count_q == 4'd15) begin
            state_d     = IDLE;
            key_ready_d = 1'b1;
            valid_d     = 1'b0;
            last_d      = 1'b0;
          end else begin
            c_d      = c_nx;
            d_d      = d_nx;
            count_d  = count_nx;
            subkey_d = pc2({c_nx, d_nx});
            idx_d    = mode_q ? (4'd14 - count_q) : count_nx;
            last_d   = (count_nx == 4'd15);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      key_ready_q <= 1'b1;
      subkey_q    <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      d_q         <= d_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      key_ready_q <= key_ready_d;
      subkey_q    <= subkey_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
    end
  end

  assign key_ready    = key_ready_q;
  assign subkey       = subkey_q;
  assign subkey_idx   = idx_q;
  assign subkey_last  = last_q;
  assign subkey_valid = valid_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Bench for des_key_sched_seq: known-answer, random keys, stalls, ignored loads, reset abort.
module tb_des_key_sched_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [63:0] key_in;
  logic        decrypt;
  logic        subkey_ready;

  logic        key_ready, subkey_last, subkey_valid, parity_err;
  logic [47:0] subkey;
  logic [3:0]  subkey_idx;
  logic        key_ready_p, subkey_last_p, subkey_valid_p, parity_err_p;
  logic [47:0] subkey_p;
  logic [3:0]  subkey_idx_p;

  int total = 0;
  int bad   = 0;
  logic [47:0] got [16];

  always #5 clk = ~clk;

  des_key_sched_seq #(.CHECK_PARITY(1'b0)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .decrypt(decrypt),
    .key_ready(key_ready), .subkey(subkey), .subkey_idx(subkey_idx),
    .subkey_last(subkey_last), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .parity_err(parity_err)
  );

  des_key_sched_seq #(.CHECK_PARITY(1'b1)) dut_p (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .decrypt(decrypt),
    .key_ready(key_ready_p), .subkey(subkey_p), .subkey_idx(subkey_idx_p),
    .subkey_last(subkey_last_p), .subkey_valid(subkey_valid_p),
    .subkey_ready(subkey_ready), .parity_err(parity_err_p)
  );

  // Standard DES tables, indexed by bit number (1 = most significant).
  int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Subkey for a round (1..16) from total left rotation, using modular indexing.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int round);
    bit kb [1:64];
    bit c0 [28];
    bit d0 [28];
    bit cd [1:56];
    int s;
    logic [47:0] r;
    for (int n = 1; n <= 64; n++) kb[n] = key[64 - n];
    for (int j = 0; j < 28; j++) begin
      c0[j] = kb[PC1[j]];
      d0[j] = kb[PC1[28 + j]];
    end
    s = 0;
    for (int i = 0; i < round; i++) s += SH[i];
    for (int j = 0; j < 28; j++) begin
      cd[j + 1]  = c0[(j + s) % 28];
      cd[j + 29] = d0[(j + s) % 28];
    end
    r = '0;
    for (int m = 0; m < 48; m++) r[47 - m] = cd[PC2[m]];
    return r;
  endfunction

  function automatic logic ref_parity_err(input logic [63:0] key);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(key[8*b +: 8]) % 2 == 0) e = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one accepted load and checks one-cycle latency.
  task automatic load(input logic [63:0] k, input logic dec);
    int n;
    n = 0;
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("load_ready", 64'(key_ready), 64'd1);
    key_in   = k;
    decrypt  = dec;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    key_in   = {$urandom, $urandom};
    decrypt  = 1'($urandom);
    chk("latency_valid", 64'(subkey_valid), 64'd1);
    chk("busy_key_ready", 64'(key_ready), 64'd0);
    chk("parity_off", 64'(parity_err), 64'd0);
    chk("parity_on", 64'(parity_err_p), 64'(ref_parity_err(k)));
  endtask

  // Loads a key and consumes n_xfer subkeys with random stalls, checking every presented cycle.
  task automatic run_seq(input logic [63:0] k, input logic dec, input int stall_pct,
                         input int n_xfer, input bit inject);
    int p, cyc, rnd;
    bit injected;
    logic [47:0] exp_sk;
    p = 0;
    cyc = 0;
    injected = 1'b0;
    load(k, dec);
    while (p < n_xfer && cyc < 2000) begin
      rnd    = dec ? 16 - p : p + 1;
      exp_sk = ref_subkey(k, rnd);
      chk("valid", 64'(subkey_valid), 64'd1);
      chk("subkey", 64'(subkey), 64'(exp_sk));
      chk("idx", 64'(subkey_idx), 64'(rnd - 1));
      chk("last", 64'(subkey_last), 64'(p == 15));
      chk("subkey_par", 64'(subkey_p), 64'(exp_sk));
      chk("gen_key_ready", 64'(key_ready), 64'd0);
      if (inject && p == 3 && !injected) begin
        key_load = 1'b1;
        key_in   = ~k;
        decrypt  = ~dec;
        injected = 1'b1;
      end else begin
        key_load = 1'b0;
      end
      subkey_ready = ($urandom_range(99) >= stall_pct);
      if (subkey_ready) begin
        got[p] = subkey;
        p++;
      end
      @(negedge clk);
      cyc++;
    end
    key_load = 1'b0;
    if (cyc >= 2000) chk("timeout", 64'd0, 64'd1);
    if (n_xfer == 16) begin
      chk("done_valid", 64'(subkey_valid), 64'd0);
      chk("done_key_ready", 64'(key_ready), 64'd1);
    end
  endtask

  localparam logic [63:0] KAT = 64'h133457799BBCDFF1;
  logic [47:0] enc_ref [16];
  logic [63:0] rk;

  initial begin
    rst = 1'b1;
    key_load = 1'b0;
    key_in = '0;
    decrypt = 1'b0;
    subkey_ready = 1'b0;
    #1;
    chk("rst_key_ready", 64'(key_ready), 64'd1);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_idx", 64'(subkey_idx), 64'd0);
    chk("rst_last", 64'(subkey_last), 64'd0);
    chk("rst_parity", 64'(parity_err_p), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Known answer, encrypt, no stalls.
    run_seq(KAT, 1'b0, 0, 16, 1'b0);
    chk("kat_k1", 64'(got[0]), 64'h1B02EFFC7072);
    chk("kat_k2", 64'(got[1]), 64'h79AED9DBC9E5);
    chk("kat_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) enc_ref[i] = got[i];

    // Known answer, decrypt, back-to-back with the previous sequence.
    run_seq(KAT, 1'b1, 0, 16, 1'b0);
    chk("kat_dec_first", 64'(got[0]), 64'hCB3D8B0E17F5);
    chk("kat_dec_second", 64'(got[1]), 64'(enc_ref[14]));
    chk("kat_dec_last", 64'(got[15]), 64'h1B02EFFC7072);

    // Stalls: same values as the stall-free run.
    run_seq(KAT, 1'b0, 50, 16, 1'b0);
    for (int i = 0; i < 16; i++) chk("stall_same", 64'(got[i]), 64'(enc_ref[i]));

    // Load during a sequence is ignored.
    run_seq(KAT, 1'b0, 40, 16, 1'b1);
    for (int i = 0; i < 16; i++) chk("ignored_load", 64'(got[i]), 64'(enc_ref[i]));

    // Parity: even last byte flagged, subkeys unchanged; all-odd key clean.
    run_seq(64'h133457799BBCDFF0, 1'b0, 0, 16, 1'b0);
    for (int i = 0; i < 16; i++) chk("parity_key_same", 64'(got[i]), 64'(enc_ref[i]));
    chk("parity_f0", 64'(parity_err_p), 64'd1);
    run_seq(64'h0101010101010101, 1'b1, 20, 16, 1'b0);
    chk("parity_0101", 64'(parity_err_p), 64'd0);

    // Reset mid-sequence aborts without a clock edge, then restarts at K1.
    run_seq(KAT, 1'b0, 30, 5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 64'(subkey_valid), 64'd0);
    chk("abort_key_ready", 64'(key_ready), 64'd1);
    chk("abort_subkey", 64'(subkey), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seq(KAT, 1'b0, 0, 16, 1'b0);
    chk("restart_k1", 64'(got[0]), 64'h1B02EFFC7072);

    // Random keys in both modes with stalls and stray loads.
    for (int t = 0; t < 6; t++) begin
      rk = {$urandom, $urandom};
      run_seq(rk, 1'(t), 50, 16, 1'(t >> 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
